instruction_memory: RTL and testbench

Program store that answers the core's instruction fetch. The core drives its program counter on ToInstructionMemory, and this block returns the addressed 8-bit instruction on FromInstructionMemroy. A byte-serial load port with a valid/ready handshake writes the program into the store. While loading, the block holds the core and serves NOPs; once loading completes, the block runs the program.

---
 rtl/instruction_memory.sv | 65 ++++++
 tb/tb_instruction_memory.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/instruction_memory.sv
// instruction_memory: byte-serial loadable program store that serves registered fetches to the core.
module instruction_memory #(
    parameter int          DEPTH       = 256,
    parameter logic [7:0]  NOP_OPCODE  = 8'h00,
    parameter logic [7:0]  HALT_OPCODE = 8'hF0
) (
    input  logic       CLK,
    input  logic       CLB,
    input  logic [7:0] ToInstructionMemory,
    output logic [7:0] FromInstructionMemroy,
    output logic       core_hold,
    input  logic       load_start,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_last,
    output logic       load_ready,
    output logic       load_error,
    output logic [8:0] prog_len
);
    localparam int         AW      = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t     state, state_nx;
    logic [7:0] mem [DEPTH];
    logic       xfer, room, hit;

    // prog_len doubles as the write pointer: both advance only on a stored byte
    assign xfer       = state == LOAD && load_valid && !load_start;
    assign room       = prog_len < DEPTH_W;
    assign hit        = state == RUN && {1'b0, ToInstructionMemory} < prog_len;
    assign core_hold  = state != RUN;
    assign load_ready = state == LOAD;

    always_comb begin
        state_nx = state;
        state_nx = load_start ? LOAD : (xfer && load_last) ? RUN : state;
    end

    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            state                 <= IDLE;
            prog_len              <= '0;
            load_error            <= 1'b0;
            FromInstructionMemroy <= NOP_OPCODE;
        end else begin
            state <= state_nx;
            if (load_start) begin
                prog_len   <= '0;
                load_error <= 1'b0;
            end else if (xfer) begin
                if (room) prog_len <= prog_len + 9'd1;
                else load_error <= 1'b1;
            end
            FromInstructionMemroy <= hit ? mem[ToInstructionMemory[AW-1:0]] :
                                     state == RUN ? HALT_OPCODE : NOP_OPCODE;
        end
    end

    // contents survive reset; only prog_len gates what is reachable
    always_ff @(posedge CLK) begin
        if (xfer && room) mem[prog_len[AW-1:0]] <= load_data;
    end
endmodule

// File: tb/tb_instruction_memory.sv
// tb_instruction_memory: directed checks of load, fetch, overflow, reprogram and reset behaviour.
module tb_instruction_memory;
    logic       CLK = 1'b0;
    logic       CLB = 1'b0;
    logic [7:0] pc = 8'h00;
    logic       load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic [7:0] dout0, dout1;
    logic       hold0, hold1, ready0, ready1, err0, err1;
    logic [8:0] len0, len1;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] prog [6];

    always #5 CLK = ~CLK;

    instruction_memory u0 (
        .CLK(CLK), .CLB(CLB), .ToInstructionMemory(pc), .FromInstructionMemroy(dout0),
        .core_hold(hold0), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(ready0),
        .load_error(err0), .prog_len(len0)
    );

    instruction_memory #(.DEPTH(4)) u1 (
        .CLK(CLK), .CLB(CLB), .ToInstructionMemory(pc), .FromInstructionMemroy(dout1),
        .core_hold(hold1), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(ready1),
        .load_error(err1), .prog_len(len1)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input int n, input bit gap, input bit last);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = last && i == n - 1;
            tick();
            load_valid = 1'b0;
            load_last  = 1'b0;
            if (gap) tick();
        end
    endtask

    task automatic fetch(input logic [7:0] a);
        pc = a;
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_dout", 9'(dout0), 9'h000);
        chk("rst_hold", 9'(hold0), 9'h001);
        chk("rst_ready", 9'(ready0), 9'h000);
        chk("rst_len", len0, 9'h000);
        chk("rst_err", 9'(err0), 9'h000);
        CLB = 1'b1;
        tick();
        chk("idle_dout", 9'(dout0), 9'h000);
        chk("idle_hold", 9'(hold0), 9'h001);
        // stray bytes in IDLE must be ignored
        load_valid = 1'b1; load_data = 8'hAA; load_last = 1'b1;
        tick();
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        chk("idle_valid_len", len0, 9'h000);
        chk("idle_valid_hold", 9'(hold0), 9'h001);
        chk("idle_valid_ready", 9'(ready0), 9'h000);
        chk("idle_valid_dout", 9'(dout0), 9'h000);

        prog = '{8'hD5, 8'h50, 8'hD3, 8'h51, 8'hF0, 8'h00};
        start();
        chk("load_ready", 9'(ready0), 9'h001);
        chk("load_hold", 9'(hold0), 9'h001);
        send(4, 1'b0, 1'b0);
        chk("load_hold_before_last", 9'(hold0), 9'h001);
        chk("load_len4", len0, 9'd4);
        prog[0] = 8'hF0;
        send(1, 1'b0, 1'b1);
        chk("run_len", len0, 9'd5);
        chk("run_hold", 9'(hold0), 9'h000);
        chk("run_ready", 9'(ready0), 9'h000);
        fetch(8'd2);   chk("fetch_pc2", 9'(dout0), 9'h0D3);
        fetch(8'd5);   chk("fetch_pc5_halt", 9'(dout0), 9'h0F0);
        fetch(8'd200); chk("fetch_pc200_halt", 9'(dout0), 9'h0F0);
        fetch(8'd0);   chk("fetch_pc0", 9'(dout0), 9'h0D5);
        fetch(8'd1);   chk("fetch_pc1", 9'(dout0), 9'h050);

        // reprogram from RUN; fetch at the start edge still sees RUN
        pc = 8'd0;
        start();
        chk("reprog_hold", 9'(hold0), 9'h001);
        tick();
        chk("reprog_nop", 9'(dout0), 9'h000);
        prog[0] = 8'h11; prog[1] = 8'h22;
        send(2, 1'b0, 1'b1);
        chk("reprog_len", len0, 9'd2);
        chk("reprog_hold_low", 9'(hold0), 9'h000);
        fetch(8'd2); chk("reprog_pc2_halt", 9'(dout0), 9'h0F0);
        fetch(8'd1); chk("reprog_pc1", 9'(dout0), 9'h022);
        fetch(8'd0); chk("reprog_pc0", 9'(dout0), 9'h011);

        prog = '{8'hD5, 8'h50, 8'hD3, 8'h51, 8'hF0, 8'h00};
        start();
        send(5, 1'b1, 1'b1);
        chk("gap_len", len0, 9'd5);
        chk("gap_hold", 9'(hold0), 9'h000);
        fetch(8'd0); chk("gap_pc0", 9'(dout0), 9'h0D5);
        fetch(8'd1); chk("gap_pc1", 9'(dout0), 9'h050);
        fetch(8'd3); chk("gap_pc3", 9'(dout0), 9'h051);

        // restart mid-load, then overflow the DEPTH=4 store
        start();
        chk("ovf_err_cleared", 9'(err1), 9'h000);
        prog[0] = 8'hAA; prog[1] = 8'hBB;
        send(2, 1'b0, 1'b0);
        chk("restart_pre_len", len0, 9'd2);
        load_start = 1'b1; load_valid = 1'b1; load_data = 8'hCC;
        tick();
        load_start = 1'b0; load_valid = 1'b0;
        chk("restart_len", len0, 9'd0);
        chk("restart_hold", 9'(hold0), 9'h001);
        prog = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send(6, 1'b0, 1'b1);
        chk("ovf_err", 9'(err1), 9'h001);
        chk("ovf_len", len1, 9'd4);
        chk("ovf_run", 9'(hold1), 9'h000);
        chk("big_len", len0, 9'd6);
        chk("big_err", 9'(err0), 9'h000);
        fetch(8'd3); chk("ovf_pc3", 9'(dout1), 9'h004);
        fetch(8'd4); chk("ovf_pc4_halt", 9'(dout1), 9'h0F0);
        chk("big_pc4", 9'(dout0), 9'h005);
        fetch(8'd0); chk("ovf_pc0", 9'(dout1), 9'h001);
        fetch(8'd5); chk("big_pc5", 9'(dout0), 9'h006);

        // asynchronous reset in the middle of a load
        start();
        send(2, 1'b0, 1'b0);
        chk("midrst_pre_len", len0, 9'd2);
        #2 CLB = 1'b0;
        #1;
        chk("midrst_len", len0, 9'd0);
        chk("midrst_hold", 9'(hold0), 9'h001);
        chk("midrst_ready", 9'(ready0), 9'h000);
        chk("midrst_dout", 9'(dout0), 9'h000);
        tick();
        CLB = 1'b1;
        tick();
        chk("post_rst_dout", 9'(dout0), 9'h000);
        chk("post_rst_hold", 9'(hold0), 9'h001);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
